kpn_channel_reader: RTL

KPN_CHANNEL_READER -- requirements
Module: kpn_channel_reader

---
 rtl/kpn_channel_reader_if.sv | 40 ++++
 rtl/kpn_channel_reader.sv | 84 ++++++++
 2 files changed

// File: rtl/kpn_channel_reader_if.sv
// Channel-reader bundle: FIFO read side plus process token side.
// master is the reader; slave is the FIFO/process environment.
interface kpn_channel_reader_if #(
  parameter int BITS_NUMBER = 16,
  parameter int COUNT_BITS  = 16
);
  logic                   fifo_empty;
  logic [BITS_NUMBER-1:0] fifo_data;
  logic                   fifo_rd;
  logic                   proc_req;
  logic                   proc_ack;
  logic                   proc_valid;
  logic [BITS_NUMBER-1:0] proc_data;
  logic                   blocked;
  logic [COUNT_BITS-1:0]  tokens_read;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  proc_req,
    input  proc_ack,
    output fifo_rd,
    output proc_valid,
    output proc_data,
    output blocked,
    output tokens_read
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output proc_req,
    output proc_ack,
    input  fifo_rd,
    input  proc_valid,
    input  proc_data,
    input  blocked,
    input  tokens_read
  );
endinterface

// File: rtl/kpn_channel_reader.sv
// Blocking-read endpoint of a KPN channel: pulls one token from the
// FIFO per request, holds it for the consumer and counts acks.
module kpn_channel_reader #(
  parameter int BITS_NUMBER = 16,
  parameter int COUNT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  kpn_channel_reader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    PRESENT
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [BITS_NUMBER-1:0] data_q;
  logic [COUNT_BITS-1:0]  count_q;
  logic                   fetch;
  logic                   ack_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // a fetch decision is only ever made against a non-empty FIFO
  always_comb begin
    state_nxt = state;
    ack_hit   = 1'b0;
    fetch     = bus.proc_req && !bus.fifo_empty;
    unique case (state)
      IDLE: begin
        if (fetch) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (bus.proc_ack) begin
          ack_hit   = 1'b1;
          state_nxt = fetch ? ISSUE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (state == CAPTURE) begin
      data_q <= bus.fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (ack_hit) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.fifo_rd     = (state == ISSUE);
  assign bus.proc_valid  = (state == PRESENT);
  assign bus.proc_data   = data_q;
  assign bus.tokens_read = count_q;
  assign bus.blocked     = (state == IDLE) && bus.proc_req
                           && bus.fifo_empty;

endmodule
